// File: rtl/cpu_mem_rd_arbiter.sv
// Memory controller front end: round-robin arbitration of RD_CHANNELS read
// requesters onto one memory read port, plus an independent registered write path.
module cpu_mem_rd_arbiter #(
  parameter int unsigned RD_CHANNELS = 2,
  parameter int unsigned MEM_DEPTH   = 32768,
  parameter int unsigned MEM_ADDR_W  = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [RD_CHANNELS-1:0]      rd_en,
  input  logic [RD_CHANNELS-1:0]      rd_size,
  input  logic [16*RD_CHANNELS-1:0]   rd_addr,
  output logic [RD_CHANNELS-1:0]      rd_done,
  output logic [16*RD_CHANNELS-1:0]   rd_data,
  output logic [RD_CHANNELS-1:0]      invalid_rd_addr,
  input  logic                        wr_en,
  input  logic                        wr_size,
  input  logic [15:0]                 wr_addr,
  input  logic [15:0]                 wr_data,
  output logic                        invalid_wr_addr,
  output logic                        mem_rd_en,
  output logic [MEM_ADDR_W-1:0]       mem_rd_addr,
  input  logic                        mem_rd_done,
  input  logic [15:0]                 mem_rd_data,
  output logic [1:0]                  mem_wr_en,
  output logic [MEM_ADDR_W-1:0]       mem_wr_addr,
  output logic [15:0]                 mem_wr_data
);

  localparam int unsigned PTR_W      = (RD_CHANNELS > 1) ? $clog2(RD_CHANNELS) : 1;
  localparam logic [16:0] ADDR_LIMIT = 17'(2 * MEM_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t                       state_q, state_d;
  logic [PTR_W-1:0]             ptr_q, ptr_d;
  logic [PTR_W-1:0]             gnt_q, gnt_d;
  logic                         byte_sel_q, byte_sel_d;
  logic                         size_q, size_d;
  logic                         mem_rd_en_q, mem_rd_en_d;
  logic [MEM_ADDR_W-1:0]        mem_rd_addr_q, mem_rd_addr_d;
  logic [RD_CHANNELS-1:0]       rd_done_q, rd_done_d;
  logic [RD_CHANNELS-1:0]       invalid_rd_q, invalid_rd_d;
  logic [16*RD_CHANNELS-1:0]    rd_data_q, rd_data_d;

  logic [1:0]                   mem_wr_en_q, mem_wr_en_d;
  logic [MEM_ADDR_W-1:0]        mem_wr_addr_q, mem_wr_addr_d;
  logic [15:0]                  mem_wr_data_q, mem_wr_data_d;
  logic                         invalid_wr_q, invalid_wr_d;

  logic                         req_found;
  logic [PTR_W-1:0]             req_idx;
  logic [PTR_W-1:0]             scan_idx;
  logic [15:0]                  req_addr;
  logic                         req_size;
  logic                         wr_conflict;

  function automatic logic addr_ok(input logic [15:0] a, input logic is_word);
    return ({1'b0, a} < ADDR_LIMIT) && !(is_word && a[0]);
  endfunction

  // Circular search starting one past the last granted channel.
  always_comb begin
    req_found = 1'b0;
    req_idx   = ptr_q;
    scan_idx  = ptr_q;
    for (int unsigned k = 0; k < RD_CHANNELS; k++) begin
      if (32'(scan_idx) == RD_CHANNELS - 1) begin
        scan_idx = '0;
      end else begin
        scan_idx = scan_idx + 1'b1;
      end
      if (!req_found && rd_en[scan_idx]) begin
        req_found = 1'b1;
        req_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    req_addr    = rd_addr[16*req_idx +: 16];
    req_size    = rd_size[req_idx];
    wr_conflict = (mem_wr_en_q != 2'b00) && (mem_wr_addr_q == req_addr[MEM_ADDR_W:1]);
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    byte_sel_d    = byte_sel_q;
    size_d        = size_q;
    mem_rd_en_d   = mem_rd_en_q;
    mem_rd_addr_d = mem_rd_addr_q;
    rd_done_d     = '0;
    invalid_rd_d  = '0;
    rd_data_d     = rd_data_q;

    case (state_q)
      S_IDLE: begin
        // A same-word write landing this cycle holds the grant back one cycle.
        if (req_found && !wr_conflict) begin
          gnt_d      = req_idx;
          ptr_d      = req_idx;
          byte_sel_d = req_addr[0];
          size_d     = req_size;
          if (addr_ok(req_addr, req_size)) begin
            state_d       = S_BUSY;
            mem_rd_en_d   = 1'b1;
            mem_rd_addr_d = req_addr[MEM_ADDR_W:1];
          end else begin
            state_d                      = S_RESP;
            rd_done_d[req_idx]           = 1'b1;
            invalid_rd_d[req_idx]        = 1'b1;
            rd_data_d[16*req_idx +: 16]  = '0;
          end
        end
      end
      S_BUSY: begin
        if (mem_rd_done) begin
          state_d            = S_RESP;
          mem_rd_en_d        = 1'b0;
          rd_done_d[gnt_q]   = 1'b1;
          if (size_q) begin
            rd_data_d[16*gnt_q +: 16] = mem_rd_data;
          end else if (byte_sel_q) begin
            rd_data_d[16*gnt_q +: 16] = {8'h00, mem_rd_data[15:8]};
          end else begin
            rd_data_d[16*gnt_q +: 16] = {8'h00, mem_rd_data[7:0]};
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        mem_rd_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      ptr_q         <= PTR_W'(RD_CHANNELS - 1);
      gnt_q         <= '0;
      byte_sel_q    <= 1'b0;
      size_q        <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      rd_done_q     <= '0;
      invalid_rd_q  <= '0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      byte_sel_q    <= byte_sel_d;
      size_q        <= size_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      rd_done_q     <= rd_done_d;
      invalid_rd_q  <= invalid_rd_d;
      rd_data_q     <= rd_data_d;
    end
  end

  always_comb begin
    mem_wr_en_d   = '0;
    invalid_wr_d  = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    if (wr_en) begin
      mem_wr_addr_d = wr_addr[MEM_ADDR_W:1];
      mem_wr_data_d = wr_size ? wr_data : {2{wr_data[7:0]}};
      if (addr_ok(wr_addr, wr_size)) begin
        mem_wr_en_d = wr_size ? 2'b11 : (wr_addr[0] ? 2'b10 : 2'b01);
      end else begin
        invalid_wr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wr_en_q   <= '0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      invalid_wr_q  <= 1'b0;
    end else begin
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      invalid_wr_q  <= invalid_wr_d;
    end
  end

  assign rd_done         = rd_done_q;
  assign rd_data         = rd_data_q;
  assign invalid_rd_addr = invalid_rd_q;
  assign mem_rd_en       = mem_rd_en_q;
  assign mem_rd_addr     = mem_rd_addr_q;
  assign mem_wr_en       = mem_wr_en_q;
  assign mem_wr_addr     = mem_wr_addr_q;
  assign mem_wr_data     = mem_wr_data_q;
  assign invalid_wr_addr = invalid_wr_q;

endmodule

// File: tb/tb_cpu_mem_rd_arbiter.sv
// Directed bench for cpu_mem_rd_arbiter: a 3-channel full-depth instance backed by
// a memory model, and a 1-channel 16-word instance for address-range boundaries.
module tb_cpu_mem_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Main instance: 3 channels, full depth.
  logic [2:0]  rd_en = '0, rd_size = '0;
  logic [47:0] rd_addr = '0;
  logic [2:0]  rd_done, invalid_rd_addr;
  logic [47:0] rd_data;
  logic        wr_en = 1'b0, wr_size = 1'b0;
  logic [15:0] wr_addr = '0, wr_data = '0;
  logic        invalid_wr_addr;
  logic        mem_rd_en;
  logic [14:0] mem_rd_addr;
  logic        mem_rd_done;
  logic [15:0] mem_rd_data;
  logic [1:0]  mem_wr_en;
  logic [14:0] mem_wr_addr;
  logic [15:0] mem_wr_data;

  cpu_mem_rd_arbiter #(.RD_CHANNELS(3), .MEM_DEPTH(32768), .MEM_ADDR_W(15)) dut (
    .clk(clk), .reset(reset),
    .rd_en(rd_en), .rd_size(rd_size), .rd_addr(rd_addr),
    .rd_done(rd_done), .rd_data(rd_data), .invalid_rd_addr(invalid_rd_addr),
    .wr_en(wr_en), .wr_size(wr_size), .wr_addr(wr_addr), .wr_data(wr_data),
    .invalid_wr_addr(invalid_wr_addr),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_done(mem_rd_done), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  // Small instance: 1 channel, 16 words (bytes 0..31 valid).
  logic [0:0]  rd_en_s = '0, rd_size_s = '0;
  logic [15:0] rd_addr_s = '0;
  logic [0:0]  rd_done_s, invalid_rd_addr_s;
  logic [15:0] rd_data_s;
  logic        wr_en_s = 1'b0, wr_size_s = 1'b0;
  logic [15:0] wr_addr_s = '0, wr_data_s = '0;
  logic        invalid_wr_addr_s;
  logic        mem_rd_en_s;
  logic [3:0]  mem_rd_addr_s;
  logic        mem_rd_done_s = 1'b0;
  logic [15:0] mem_rd_data_s = '0;
  logic [1:0]  mem_wr_en_s;
  logic [3:0]  mem_wr_addr_s;
  logic [15:0] mem_wr_data_s;

  cpu_mem_rd_arbiter #(.RD_CHANNELS(1), .MEM_DEPTH(16), .MEM_ADDR_W(4)) dut_s (
    .clk(clk), .reset(reset),
    .rd_en(rd_en_s), .rd_size(rd_size_s), .rd_addr(rd_addr_s),
    .rd_done(rd_done_s), .rd_data(rd_data_s), .invalid_rd_addr(invalid_rd_addr_s),
    .wr_en(wr_en_s), .wr_size(wr_size_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .invalid_wr_addr(invalid_wr_addr_s),
    .mem_rd_en(mem_rd_en_s), .mem_rd_addr(mem_rd_addr_s),
    .mem_rd_done(mem_rd_done_s), .mem_rd_data(mem_rd_data_s),
    .mem_wr_en(mem_wr_en_s), .mem_wr_addr(mem_wr_addr_s), .mem_wr_data(mem_wr_data_s)
  );

  // Memory model for the main instance; applies lane writes and answers reads.
  logic [15:0] mem_model [logic [14:0]];
  int          wait_cycles = 0;
  bit          manual = 1'b0;
  int          done_req = 0;

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[7:0] ^ 8'h3C, a[7:0]};
  endfunction

  initial begin
    int          wait_cnt;
    int          done_ack;
    logic [15:0] w;
    wait_cnt    = 0;
    done_ack    = 0;
    mem_rd_done = 1'b0;
    mem_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_wr_en != 2'b00) begin
        w = mem_word(mem_wr_addr);
        if (mem_wr_en[0]) w[7:0]  = mem_wr_data[7:0];
        if (mem_wr_en[1]) w[15:8] = mem_wr_data[15:8];
        mem_model[mem_wr_addr] = w;
      end
      if (mem_rd_done) begin
        mem_rd_done = 1'b0;
      end else if (manual) begin
        if (done_req != done_ack) begin
          done_ack    = done_req;
          mem_rd_done = 1'b1;
          mem_rd_data = 16'hDEAD;
        end
      end else if (mem_rd_en) begin
        if (wait_cnt < wait_cycles) begin
          wait_cnt++;
        end else begin
          wait_cnt    = 0;
          mem_rd_done = 1'b1;
          mem_rd_data = mem_word(mem_rd_addr);
        end
      end
    end
  end

  typedef struct {
    int          chan;
    logic [15:0] data;
    logic        err;
    string       tag;
  } rd_exp_t;

  typedef struct {
    logic [1:0]  en;
    logic [14:0] addr;
    logic [15:0] data;
    logic        inv;
    string       tag;
  } wr_exp_t;

  rd_exp_t rdq[$];
  wr_exp_t wq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_rd(input int c, input logic sz, input logic [15:0] a);
    rd_en[c]          = 1'b1;
    rd_size[c]        = sz;
    rd_addr[16*c +: 16] = a;
  endtask

  task automatic push_rd(input int c, input logic [15:0] d, input logic e, input string tag);
    rd_exp_t x;
    x.chan = c; x.data = d; x.err = e; x.tag = tag;
    rdq.push_back(x);
  endtask

  // Waits for the next rd_done pulse and checks it against the scoreboard head.
  task automatic expect_rd_done(input int exp_lat, input bit drop);
    int      lat;
    bit      seen;
    rd_exp_t e;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (rd_done != 3'b000) seen = 1'b1;
    end
    if (rdq.size() == 0) begin
      checks++; failures++;
      $error("FAIL rd_scoreboard observed=empty expected=entry");
      return;
    end
    e = rdq.pop_front();
    if (!seen) begin
      checks++; failures++;
      $error("FAIL %s_timeout observed=no_rd_done expected=rd_done", e.tag);
      return;
    end
    chk({e.tag, "_done"}, rd_done, 64'(1) << e.chan);
    chk({e.tag, "_data"}, rd_data[16*e.chan +: 16], e.data);
    chk({e.tag, "_inv"}, invalid_rd_addr, e.err ? (64'(1) << e.chan) : 64'(0));
    if (exp_lat > 0) chk({e.tag, "_lat"}, lat, exp_lat);
    if (drop) rd_en[e.chan] = 1'b0;
  endtask

  task automatic write_step(input logic sz, input logic [15:0] a, input logic [15:0] d,
                            input logic [1:0] exp_en, input logic [15:0] exp_data,
                            input string tag);
    wr_exp_t e;
    wr_en = 1'b1; wr_size = sz; wr_addr = a; wr_data = d;
    e.en = exp_en; e.addr = a[15:1]; e.data = exp_data; e.inv = (exp_en == 2'b00); e.tag = tag;
    wq.push_back(e);
    @(posedge clk); #1;
    wr_en = 1'b0;
    e = wq.pop_front();
    chk({e.tag, "_wen"}, mem_wr_en, e.en);
    chk({e.tag, "_waddr"}, mem_wr_addr, e.addr);
    chk({e.tag, "_winv"}, invalid_wr_addr, e.inv);
    if (!e.inv) chk({e.tag, "_wdata"}, mem_wr_data, e.data);
  endtask

  task automatic do_reset();
    rd_en = '0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    chk("rst_rd_done", rd_done, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_inv_wr", invalid_wr_addr, 0);
    chk("rst_s_rd_done", rd_done_s, 0);
    reset = 1'b0;
    tick(1);

    // Word read, 2 wait cycles.
    write_step(1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'hBEEF, "pre_beef");
    tick(2);
    wait_cycles = 2;
    push_rd(0, 16'hBEEF, 1'b0, "rd_word");
    start_rd(0, 1'b1, 16'h0010);
    tick(1);
    chk("rd_word_mem_en", mem_rd_en, 1);
    chk("rd_word_mem_addr", mem_rd_addr, 15'h0008);
    expect_rd_done(3, 1'b1);
    tick(1);
    chk("rd_word_single_pulse", rd_done, 0);
    wait_cycles = 0;

    // Byte reads, with hold of the other channel's data.
    write_step(1'b1, 16'h0010, 16'hA55A, 2'b11, 16'hA55A, "pre_a55a");
    tick(2);
    push_rd(1, 16'h00A5, 1'b0, "rd_byte_hi");
    start_rd(1, 1'b0, 16'h0011);
    expect_rd_done(2, 1'b1);
    chk("rd_hold_ch0", rd_data[15:0], 16'hBEEF);
    tick(1);
    push_rd(0, 16'h005A, 1'b0, "rd_byte_lo");
    start_rd(0, 1'b0, 16'h0010);
    expect_rd_done(2, 1'b1);

    // Misaligned word read is rejected without a memory access.
    tick(1);
    push_rd(0, 16'h0000, 1'b1, "rd_misalign");
    start_rd(0, 1'b1, 16'h0003);
    expect_rd_done(1, 1'b1);
    chk("rd_misalign_no_mem", mem_rd_en, 0);
    tick(1);
    chk("rd_misalign_no_mem2", mem_rd_en, 0);

    // Write path.
    write_step(1'b0, 16'h0021, 16'h00CD, 2'b10, 16'hCDCD, "wr_byte_hi");
    write_step(1'b1, 16'h0021, 16'h1234, 2'b00, 16'h0000, "wr_word_odd");
    write_step(1'b0, 16'h0020, 16'h0077, 2'b01, 16'h7777, "wr_b2b_lo");
    write_step(1'b1, 16'h0040, 16'hABCD, 2'b11, 16'hABCD, "wr_b2b_word");
    tick(1);
    chk("wr_idle_en", mem_wr_en, 0);
    chk("wr_idle_inv", invalid_wr_addr, 0);

    // Read of a word being written in the same cycle is deferred once.
    tick(1);
    write_step(1'b1, 16'h0030, 16'h1111, 2'b11, 16'h1111, "pre_defer");
    push_rd(0, 16'h1111, 1'b0, "rd_defer");
    start_rd(0, 1'b1, 16'h0030);
    tick(1);
    chk("defer_hold", mem_rd_en, 0);
    tick(1);
    chk("defer_grant", mem_rd_en, 1);
    expect_rd_done(1, 1'b1);

    // Two channels requesting continuously alternate.
    tick(1);
    do_reset();
    push_rd(0, mem_word(15'h0080), 1'b0, "rr2_a");
    push_rd(1, mem_word(15'h0100), 1'b0, "rr2_b");
    push_rd(0, mem_word(15'h0080), 1'b0, "rr2_c");
    push_rd(1, mem_word(15'h0100), 1'b0, "rr2_d");
    start_rd(0, 1'b1, 16'h0100);
    start_rd(1, 1'b1, 16'h0200);
    expect_rd_done(2, 1'b0);
    expect_rd_done(3, 1'b0);
    expect_rd_done(3, 1'b0);
    expect_rd_done(3, 1'b1);
    rd_en = '0;
    tick(1);
    chk("rr2_quiet", rd_done, 0);
    tick(1);
    chk("rr2_no_regrant", mem_rd_en, 0);

    // Three channels.
    do_reset();
    push_rd(0, mem_word(15'h0080), 1'b0, "rr3_a");
    push_rd(1, mem_word(15'h0100), 1'b0, "rr3_b");
    push_rd(2, mem_word(15'h0180), 1'b0, "rr3_c");
    push_rd(0, mem_word(15'h0080), 1'b0, "rr3_d");
    start_rd(0, 1'b1, 16'h0100);
    start_rd(1, 1'b1, 16'h0200);
    start_rd(2, 1'b1, 16'h0300);
    expect_rd_done(2, 1'b0);
    expect_rd_done(3, 1'b0);
    expect_rd_done(3, 1'b0);
    expect_rd_done(3, 1'b1);
    rd_en = '0;
    tick(2);

    // Reset while BUSY, then a stray mem_rd_done.
    manual = 1'b1;
    start_rd(0, 1'b1, 16'h0010);
    tick(1);
    chk("rstbusy_busy", mem_rd_en, 1);
    rd_en = '0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("rstbusy_abort", mem_rd_en, 0);
    done_req++;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("rstbusy_no_done", rd_done, 0);
    end
    chk("rstbusy_idle", mem_rd_en, 0);
    manual = 1'b0;
    push_rd(0, mem_word(15'h0080), 1'b0, "rstbusy_next0");
    push_rd(1, mem_word(15'h0100), 1'b0, "rstbusy_next1");
    start_rd(0, 1'b1, 16'h0100);
    start_rd(1, 1'b1, 16'h0200);
    expect_rd_done(2, 1'b1);
    expect_rd_done(3, 1'b1);
    tick(1);

    // Depth-16 instance: range boundaries.
    rd_en_s = 1'b1; rd_size_s = 1'b1; rd_addr_s = 16'hFFFE;
    tick(1);
    rd_en_s = 1'b0;
    chk("s_fffe_done", rd_done_s, 1);
    chk("s_fffe_inv", invalid_rd_addr_s, 1);
    chk("s_fffe_data", rd_data_s, 0);
    chk("s_fffe_no_mem", mem_rd_en_s, 0);
    tick(1);
    chk("s_fffe_pulse", rd_done_s, 0);
    tick(1);
    rd_en_s = 1'b1; rd_size_s = 1'b0; rd_addr_s = 16'h0020;
    tick(1);
    rd_en_s = 1'b0;
    chk("s_0020_done", rd_done_s, 1);
    chk("s_0020_inv", invalid_rd_addr_s, 1);
    chk("s_0020_no_mem", mem_rd_en_s, 0);
    wr_en_s = 1'b1; wr_size_s = 1'b0; wr_addr_s = 16'h0020; wr_data_s = 16'h0099;
    tick(1);
    chk("s_wr20_inv", invalid_wr_addr_s, 1);
    chk("s_wr20_en", mem_wr_en_s, 0);
    wr_addr_s = 16'h001F;
    tick(1);
    wr_en_s = 1'b0;
    chk("s_wr1f_inv", invalid_wr_addr_s, 0);
    chk("s_wr1f_en", mem_wr_en_s, 2'b10);
    chk("s_wr1f_addr", mem_wr_addr_s, 4'hF);
    chk("s_wr1f_data", mem_wr_data_s, 16'h9999);
    tick(1);
    chk("s_wr_idle", mem_wr_en_s, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
